// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC select with a RUN/EXC exception FSM; one-cycle latency, no backpressure.
// Optional target-alignment check is built only when `PC_ALIGN_CHECK_EN is defined.
module pc_next_unit #(
   parameter int               WIDTH        = 32,
   parameter int               NUM_SRC      = 5,
   parameter int               SEL_W        = 3,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_00FF)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [SEL_W-1:0]         selector,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic                     pc_write,
   input  logic                     pc_write_cond,
   input  logic                     branch_take,
   input  logic                     exc_req,
   input  logic                     eret,
   output logic [WIDTH-1:0]         pc_out,
   output logic [WIDTH-1:0]         epc_out,
   output logic                     in_exc,
   output logic                     sel_err,
   output logic                     misalign
);

   typedef enum logic {
      RUN = 1'b0,
      EXC = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             sel_err_q, sel_err_d;
   logic [WIDTH-1:0] target;
   logic             wr_en;
   logic             sel_ok;
   logic             mis_wr;

   assign wr_en  = pc_write | (pc_write_cond & branch_take);
   assign sel_ok = int'(selector) < NUM_SRC;

   always_comb begin
      target = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (int'(selector) == k) begin
            target = src_data[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   // A misaligned write only wins when no explicit exception outranks it.
   assign mis_wr     = wr_en & sel_ok & (target[1:0] != 2'b00);
   assign misalign_d = mis_wr & ~exc_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign = misalign_q;
`else
   assign mis_wr   = 1'b0;
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      epc_d     = epc_q;
      sel_err_d = 1'b0;
      if (exc_req || mis_wr) begin
         pc_d = EXC_VECTOR;
         // Exceptions do not nest: epc is captured only on entry from RUN.
         if (state_q == RUN) begin
            epc_d   = pc_q;
            state_d = EXC;
         end
      end else if (eret && (state_q == EXC)) begin
         pc_d    = epc_q;
         state_d = RUN;
      end else if (wr_en) begin
         if (sel_ok) begin
            pc_d = target;
         end else begin
            sel_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RUN;
         pc_q      <= RESET_VECTOR;
         epc_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign pc_out  = pc_q;
   assign epc_out = epc_q;
   assign in_exc  = (state_q == EXC);
   assign sel_err = sel_err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: table-driven steps, expected outputs queued at drive time and popped after each edge.
module tb_pc_next_unit;

   logic         clk;
   logic         reset_n;
   logic [2:0]   selector;
   logic [159:0] src_data;
   logic         pc_write, pc_write_cond, branch_take, exc_req, eret;
   logic [31:0]  pc_out, epc_out;
   logic         in_exc, sel_err, misalign;

   typedef struct packed {
      logic [2:0]  sel;
      logic        pw, pwc, bt, exc, er;
      logic [31:0] pc, epc;
      logic        ie, se, ma;
   } step_t;

   typedef struct packed {
      logic [31:0] pc, epc;
      logic        ie, se, ma;
   } out_t;

   out_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   pc_next_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .selector     (selector),
      .src_data     (src_data),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .branch_take  (branch_take),
      .exc_req      (exc_req),
      .eret         (eret),
      .pc_out       (pc_out),
      .epc_out      (epc_out),
      .in_exc       (in_exc),
      .sel_err      (sel_err),
      .misalign     (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic step_t st(int sel, int pw, int pwc, int bt, int exc, int er,
                                int pc, int epc, int ie, int se, int ma);
      step_t r;
      r.sel = 3'(sel); r.pw = 1'(pw); r.pwc = 1'(pwc); r.bt = 1'(bt);
      r.exc = 1'(exc); r.er = 1'(er);
      r.pc = 32'(pc); r.epc = 32'(epc);
      r.ie = 1'(ie); r.se = 1'(se); r.ma = 1'(ma);
      return r;
   endfunction

   function automatic out_t obs();
      out_t o;
      o.pc = pc_out; o.epc = epc_out; o.ie = in_exc; o.se = sel_err; o.ma = misalign;
      return o;
   endfunction

   // Drive one step's inputs and queue what the DUT must show after the next edge.
   task automatic apply(input step_t s);
      out_t e;
      selector = s.sel; pc_write = s.pw; pc_write_cond = s.pwc;
      branch_take = s.bt; exc_req = s.exc; eret = s.er;
      e.pc = s.pc; e.epc = s.epc; e.ie = s.ie; e.se = s.se; e.ma = s.ma;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      out_t o, e;
      step_t s;
      reset_n = 1'b0;
      selector = 3'd0; pc_write = 1'b0; pc_write_cond = 1'b0;
      branch_take = 1'b0; exc_req = 1'b0; eret = 1'b0;
      #2;
      o = obs();
      e = '{pc: 32'h0, epc: 32'h0, ie: 1'b0, se: 1'b0, ma: 1'b0};
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_state: got pc=%h epc=%h ie=%b se=%b ma=%b want pc=%h epc=%h ie=%b se=%b ma=%b",
                  o.pc, o.epc, o.ie, o.se, o.ma, e.pc, e.epc, e.ie, e.se, e.ma);
      end
      reset_n = 1'b1;
      s = st(4, 1, 0, 0, 0, 0, 'h80, 0, 0, 0, 0);
      apply(s);
      tick();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL first_write_after_reset: got pc=%h epc=%h ie=%b want pc=%h epc=%h ie=%b",
                  o.pc, o.epc, o.ie, e.pc, e.epc, e.ie);
      end
   endtask

   task automatic test_write_hold();
      step_t s[6];
      out_t o, e;
      s[0] = st(2, 1, 0, 0, 0, 0, 'h40,  0, 0, 0, 0);
      s[1] = st(0, 0, 1, 0, 0, 0, 'h40,  0, 0, 0, 0);
      s[2] = st(0, 0, 1, 1, 0, 0, 'h100, 0, 0, 0, 0);
      s[3] = st(1, 0, 0, 1, 0, 0, 'h100, 0, 0, 0, 0);
      s[4] = st(2, 1, 0, 0, 0, 0, 'h40,  0, 0, 0, 0);
      s[5] = st(4, 0, 0, 0, 0, 0, 'h40,  0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         apply(s[i]);
         tick();
         e = sb.pop_front();
         o = obs();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL write_hold step %0d: got pc=%h epc=%h ie=%b se=%b ma=%b want pc=%h epc=%h ie=%b se=%b ma=%b",
                     i, o.pc, o.epc, o.ie, o.se, o.ma, e.pc, e.epc, e.ie, e.se, e.ma);
         end
      end
   endtask

   task automatic test_exception();
      step_t s[11];
      out_t o, e;
      s[0]  = st(0, 1, 0, 0, 1, 0, 'hFF,  'h40, 1, 0, 0);
      s[1]  = st(0, 0, 0, 0, 1, 0, 'hFF,  'h40, 1, 0, 0);
      s[2]  = st(4, 1, 0, 0, 0, 0, 'h80,  'h40, 1, 0, 0);
      s[3]  = st(0, 0, 0, 0, 0, 1, 'h40,  'h40, 0, 0, 0);
      s[4]  = st(0, 0, 0, 0, 0, 1, 'h40,  'h40, 0, 0, 0);
      s[5]  = st(0, 1, 0, 0, 0, 1, 'h100, 'h40, 0, 0, 0);
      s[6]  = st(2, 1, 0, 0, 0, 0, 'h40,  'h40, 0, 0, 0);
      s[7]  = st(0, 0, 0, 0, 1, 0, 'hFF,  'h40, 1, 0, 0);
      s[8]  = st(0, 0, 0, 0, 1, 1, 'hFF,  'h40, 1, 0, 0);
      s[9]  = st(7, 1, 0, 0, 0, 1, 'h40,  'h40, 0, 0, 0);
      s[10] = st(0, 0, 0, 0, 0, 0, 'h40,  'h40, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         apply(s[i]);
         tick();
         e = sb.pop_front();
         o = obs();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL exception step %0d: got pc=%h epc=%h ie=%b se=%b ma=%b want pc=%h epc=%h ie=%b se=%b ma=%b",
                     i, o.pc, o.epc, o.ie, o.se, o.ma, e.pc, e.epc, e.ie, e.se, e.ma);
         end
      end
   endtask

   task automatic test_sel_err();
      step_t s[5];
      out_t o, e;
      s[0] = st(7, 1, 0, 0, 0, 0, 'h40, 'h40, 0, 1, 0);
      s[1] = st(0, 0, 0, 0, 0, 0, 'h40, 'h40, 0, 0, 0);
      s[2] = st(5, 0, 1, 1, 0, 0, 'h40, 'h40, 0, 1, 0);
      s[3] = st(6, 0, 1, 0, 0, 0, 'h40, 'h40, 0, 0, 0);
      s[4] = st(6, 1, 0, 0, 0, 0, 'h40, 'h40, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         apply(s[i]);
         tick();
         e = sb.pop_front();
         o = obs();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL sel_err step %0d: got pc=%h epc=%h ie=%b se=%b ma=%b want pc=%h epc=%h ie=%b se=%b ma=%b",
                     i, o.pc, o.epc, o.ie, o.se, o.ma, e.pc, e.epc, e.ie, e.se, e.ma);
         end
      end
   endtask

   task automatic test_misalign();
      step_t s[4];
      out_t o, e;
`ifdef PC_ALIGN_CHECK_EN
      s[0] = st(3, 1, 0, 0, 0, 0, 'hFF, 'h40, 1, 0, 1);
      s[1] = st(0, 0, 0, 0, 0, 0, 'hFF, 'h40, 1, 0, 0);
      s[2] = st(2, 1, 0, 0, 0, 1, 'h40, 'h40, 0, 0, 0);
      s[3] = st(3, 1, 0, 0, 1, 0, 'hFF, 'h40, 1, 0, 0);
`else
      s[0] = st(3, 1, 0, 0, 0, 0, 'h42, 'h40, 0, 0, 0);
      s[1] = st(0, 0, 0, 0, 0, 0, 'h42, 'h40, 0, 0, 0);
      s[2] = st(2, 1, 0, 0, 0, 1, 'h40, 'h40, 0, 0, 0);
      s[3] = st(3, 1, 0, 0, 1, 0, 'hFF, 'h40, 1, 0, 0);
`endif
      for (int i = 0; i < 4; i++) begin
         apply(s[i]);
         tick();
         e = sb.pop_front();
         o = obs();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL misalign step %0d: got pc=%h epc=%h ie=%b se=%b ma=%b want pc=%h epc=%h ie=%b se=%b ma=%b",
                     i, o.pc, o.epc, o.ie, o.se, o.ma, e.pc, e.epc, e.ie, e.se, e.ma);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[6];
      out_t o, e;
      s[0] = st(0, 0, 0, 0, 0, 1, 'h40,  'h40, 0, 0, 0);
      s[1] = st(0, 1, 0, 0, 0, 0, 'h100, 'h40, 0, 0, 0);
      s[2] = st(1, 0, 1, 1, 0, 0, 'h200, 'h40, 0, 0, 0);
      s[3] = st(2, 1, 0, 0, 0, 0, 'h40,  'h40, 0, 0, 0);
      s[4] = st(4, 1, 1, 1, 0, 0, 'h80,  'h40, 0, 0, 0);
      s[5] = st(0, 1, 0, 0, 0, 0, 'h100, 'h40, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         apply(s[i]);
         tick();
         e = sb.pop_front();
         o = obs();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got pc=%h epc=%h ie=%b se=%b ma=%b want pc=%h epc=%h ie=%b se=%b ma=%b",
                     i, o.pc, o.epc, o.ie, o.se, o.ma, e.pc, e.epc, e.ie, e.se, e.ma);
         end
      end
   endtask

   task automatic test_reset_mid_exc();
      step_t s;
      out_t o, e;
      s = st(0, 0, 0, 0, 1, 0, 'hFF, 'h100, 1, 0, 0);
      apply(s);
      tick();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL exc_before_reset: got pc=%h epc=%h ie=%b want pc=%h epc=%h ie=%b",
                  o.pc, o.epc, o.ie, e.pc, e.epc, e.ie);
      end
      exc_req = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      o = obs();
      e = '{pc: 32'h0, epc: 32'h0, ie: 1'b0, se: 1'b0, ma: 1'b0};
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL async_reset_mid_exc: got pc=%h epc=%h ie=%b want pc=%h epc=%h ie=%b",
                  o.pc, o.epc, o.ie, e.pc, e.epc, e.ie);
      end
      #1;
      reset_n = 1'b1;
      s = st(2, 1, 0, 0, 0, 0, 'h40, 0, 0, 0, 0);
      apply(s);
      tick();
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL write_after_mid_reset: got pc=%h epc=%h ie=%b want pc=%h epc=%h ie=%b",
                  o.pc, o.epc, o.ie, e.pc, e.epc, e.ie);
      end
   endtask

   initial begin
      src_data = {32'h0000_0080, 32'h0000_0042, 32'h0000_0040, 32'h0000_0200, 32'h0000_0100};
      test_reset();
      test_write_hold();
      test_exception();
      test_sel_err();
      test_misalign();
      test_back_to_back();
      test_reset_mid_exc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/data width in bits (minimum 8).
REQ-002 SHALL have parameter NUM_SRC, default 5, meaning the number of next-PC source channels (2..16).
REQ-003 SHALL have parameter SEL_W, default 3, meaning selector width, which SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value after reset.
REQ-005 SHALL have parameter EXC_VECTOR, default 32'h0000_00FF, meaning the PC value loaded on exception entry.
REQ-006 SHALL have port clk, input, 1 bit, the sole clock; all state SHALL update on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit, the reset; it SHALL be asynchronous and active-low.
REQ-008 SHALL have port selector, input, SEL_W bits, the next-PC source index.
REQ-009 SHALL have port src_data, input, NUM_SRC*WIDTH bits, the flat source bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port pc_write, input, 1 bit, the unconditional PC write enable.
REQ-011 SHALL have port pc_write_cond, input, 1 bit, the conditional (branch) write enable.
REQ-012 SHALL have port branch_take, input, 1 bit, the branch condition qualifying pc_write_cond.
REQ-013 SHALL have port exc_req, input, 1 bit, the synchronous exception request.
REQ-014 SHALL have port eret, input, 1 bit, the exception-return request.
REQ-015 SHALL have port pc_out, output, WIDTH bits, the registered current PC.
REQ-016 SHALL have port epc_out, output, WIDTH bits, the registered exception PC.
REQ-017 SHALL have port in_exc, output, 1 bit, high while in state EXC.
REQ-018 SHALL have port sel_err, output, 1 bit, a registered one-cycle pulse flagging a write attempted with selector >= NUM_SRC.
REQ-019 SHALL have port misalign, output, 1 bit, a registered one-cycle pulse flagging a misaligned target (see REQ-030).

Function
REQ-020 SHALL compute wr_en = pc_write | (pc_write_cond & branch_take).
REQ-021 SHALL compute target = channel[selector] combinationally; all outputs SHALL be registered.
REQ-022 SHALL implement a two-state FSM: RUN and EXC.
REQ-023 Each cycle SHALL apply exactly one action, highest priority first:
- exc_req
- misaligned write
- eret
- wr_en
- hold.
REQ-024 exc_req in RUN: epc <= pc_out, pc <= EXC_VECTOR, state <= EXC, all in one cycle.
REQ-025 exc_req in EXC: pc <= EXC_VECTOR; epc unchanged; state remains EXC (no nesting).
REQ-026 eret in EXC: pc <= epc, state <= RUN; eret in RUN SHALL be ignored and the cycle falls through to the next priority.
REQ-027 wr_en with selector < NUM_SRC: pc <= target, effective the next edge (latency 1).
REQ-028 wr_en with selector >= NUM_SRC: pc holds and sel_err pulses for 1 cycle.
REQ-029 wr_en low and no other event: pc, epc and state hold.
REQ-030 wr_en resolving to target[1:0] != 0 SHALL be treated as an exception per REQ-024/025, with misalign pulsing for 1 cycle.
REQ-031 Arithmetic: none; the PC SHALL never be incremented internally; all values pass through at full WIDTH.

Reset
REQ-032 On reset_n low, the block SHALL asynchronously set pc_out = RESET_VECTOR, epc_out = 0, state = RUN, in_exc = 0, sel_err = 0, misalign = 0.
REQ-033 Reset asserted mid-exception SHALL discard epc and return to RUN; the first post-reset write SHALL be honoured on the first rising edge after reset_n rises.

Configuration
REQ-034 Macro PC_ALIGN_CHECK_EN:
- Defined: REQ-030 is active.
- Undefined: targets load unchecked, misalign is tied to 0, and its logic is removed.

Verification
REQ-035 Reset with reset_n=0 mid-cycle -> pc_out=0x00000000 immediately, before any clock edge; epc_out=0; in_exc=0.
REQ-036 selector=2, channel2=0x00000040, pc_write=1 -> pc_out=0x00000040 after 1 edge; then pc_write_cond=1 with branch_take=0 -> pc holds.
REQ-037 pc_out=0x00000040, exc_req=1 and pc_write=1 in the same cycle -> pc_out=0x000000FF, epc_out=0x00000040, in_exc=1; then eret -> pc_out=0x00000040, in_exc=0.
REQ-038 selector=7, NUM_SRC=5, pc_write=1 -> pc holds and sel_err pulses high for exactly 1 cycle.
REQ-039 With PC_ALIGN_CHECK_EN defined, target 0x00000042 -> misalign pulses and pc_out=0x000000FF; without the macro -> pc_out=0x00000042.
REQ-040 In EXC with epc_out=0x40, a second exc_req -> epc_out stays 0x40; eret issued in RUN -> no effect.
